// File: rtl/pc_gen_pkg.sv
// Shared constants for the fetch-stage PC generator family.
package pc_gen_pkg;
    localparam int   ADDR_W_DEF     = 32;
    localparam int   INST_BYTES_DEF = 4;
    localparam logic RST_ENABLE     = 1'b0;
    localparam logic NO_STOP        = 1'b0;
    localparam logic STOP           = 1'b1;
endpackage

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer: combinational lookup, falling-edge update.
import pc_gen_pkg::*;

module pc_btb #(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int BTB_DEPTH  = 8,
    parameter int INST_BYTES = INST_BYTES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] lookup_pc,
    output logic              hit,
    output logic [ADDR_W-1:0] target,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_taken
);
    localparam int IDX_W = $clog2(BTB_DEPTH);
    localparam int OFF_W = $clog2(INST_BYTES);
    localparam int TAG_W = ADDR_W - OFF_W - IDX_W;

    logic [BTB_DEPTH-1:0] valid_q;
    logic [TAG_W-1:0]     tag_q [BTB_DEPTH];
    logic [ADDR_W-1:0]    tgt_q [BTB_DEPTH];

    logic [IDX_W-1:0] rd_idx;
    logic [TAG_W-1:0] rd_tag;
    logic [IDX_W-1:0] wr_idx;
    logic [TAG_W-1:0] wr_tag;
    logic             unused_off;

    assign rd_idx = lookup_pc[OFF_W +: IDX_W];
    assign rd_tag = lookup_pc[ADDR_W-1 : OFF_W+IDX_W];
    assign wr_idx = upd_pc[OFF_W +: IDX_W];
    assign wr_tag = upd_pc[ADDR_W-1 : OFF_W+IDX_W];
    // Byte-offset bits never take part in indexing or tagging.
    assign unused_off = ^{lookup_pc[OFF_W-1:0], upd_pc[OFF_W-1:0]};

    assign hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign target = hit ? tgt_q[rd_idx] : '0;

    always_ff @(negedge clk) begin
        if (rst == RST_ENABLE) begin
            valid_q <= '0;
        end else if (upd_valid) begin
            if (upd_taken) begin
                valid_q[wr_idx] <= 1'b1;
                tag_q[wr_idx]   <= wr_tag;
                tgt_q[wr_idx]   <= upd_target;
            end else if (valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag)) begin
                valid_q[wr_idx] <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/pc_gen.sv
// Next-PC generator: prioritised redirects, stall-time pending buffer,
// BTB prediction and sequential successor.
import pc_gen_pkg::*;

module pc_gen #(
    parameter int              ADDR_W     = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int              INST_BYTES = INST_BYTES_DEF,
    parameter int              NUM_RD     = 2,
    parameter int              BTB_DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall_i,
    input  logic [NUM_RD-1:0]        rd_valid_i,
    input  logic [NUM_RD*ADDR_W-1:0] rd_target_i,
    input  logic                     bu_valid_i,
    input  logic [ADDR_W-1:0]        bu_pc_i,
    input  logic [ADDR_W-1:0]        bu_target_i,
    input  logic                     bu_taken_i,
    output logic [ADDR_W-1:0]        pc_o,
    output logic                     pred_taken_o,
    output logic [ADDR_W-1:0]        pred_target_o,
    output logic                     pending_o
);
    logic [ADDR_W-1:0] pc_q;
    logic              pend_q;
    logic [ADDR_W-1:0] pend_tgt_q;
    logic              live;
    logic [ADDR_W-1:0] live_tgt;
    logic [ADDR_W-1:0] next_pc;

    pc_btb #(
        .ADDR_W    (ADDR_W),
        .BTB_DEPTH (BTB_DEPTH),
        .INST_BYTES(INST_BYTES)
    ) u_btb (
        .clk       (clk),
        .rst       (rst),
        .lookup_pc (pc_q),
        .hit       (pred_taken_o),
        .target    (pred_target_o),
        .upd_valid (bu_valid_i),
        .upd_pc    (bu_pc_i),
        .upd_target(bu_target_i),
        .upd_taken (bu_taken_i)
    );

    // Scan downward so the lowest-index valid channel wins.
    always_comb begin
        live     = 1'b0;
        live_tgt = '0;
        for (int k = NUM_RD - 1; k >= 0; k--) begin
            if (rd_valid_i[k]) begin
                live     = 1'b1;
                live_tgt = rd_target_i[k*ADDR_W +: ADDR_W];
            end
        end
    end

    always_comb begin
        next_pc = pc_q + ADDR_W'(INST_BYTES);
        if (live)
            next_pc = live_tgt;
        else if (pend_q)
            next_pc = pend_tgt_q;
        else if (pred_taken_o)
            next_pc = pred_target_o;
    end

    always_ff @(negedge clk) begin
        if (rst == RST_ENABLE) begin
            pc_q       <= RESET_PC;
            pend_q     <= 1'b0;
            pend_tgt_q <= '0;
        end else if (stall_i == NO_STOP) begin
            pc_q   <= next_pc;
            pend_q <= 1'b0;
        end else if (live) begin
            pend_q     <= 1'b1;
            pend_tgt_q <= live_tgt;
        end
    end

    assign pc_o      = pc_q;
    assign pending_o = pend_q;
endmodule

// File: tb/tb_pc_gen.sv
// Directed scoreboard bench for pc_gen (falling-edge design).
module tb_pc_gen;
    logic        clk;
    logic        rst;
    logic        stall_i;
    logic [1:0]  rd_valid_i;
    logic [63:0] rd_target_i;
    logic        bu_valid_i;
    logic [31:0] bu_pc_i;
    logic [31:0] bu_target_i;
    logic        bu_taken_i;
    logic [31:0] pc_o;
    logic        pred_taken_o;
    logic [31:0] pred_target_o;
    logic        pending_o;
    logic [31:0] pc_w;
    logic        pred_taken_w;
    logic [31:0] pred_target_w;
    logic        pending_w;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        pend;
        logic        pt;
        logic [31:0] ptgt;
    } exp_t;

    exp_t sb[$];

    pc_gen dut (
        .clk(clk), .rst(rst), .stall_i(stall_i),
        .rd_valid_i(rd_valid_i), .rd_target_i(rd_target_i),
        .bu_valid_i(bu_valid_i), .bu_pc_i(bu_pc_i),
        .bu_target_i(bu_target_i), .bu_taken_i(bu_taken_i),
        .pc_o(pc_o), .pred_taken_o(pred_taken_o),
        .pred_target_o(pred_target_o), .pending_o(pending_o)
    );

    pc_gen #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst), .stall_i(stall_i),
        .rd_valid_i(rd_valid_i), .rd_target_i(rd_target_i),
        .bu_valid_i(bu_valid_i), .bu_pc_i(bu_pc_i),
        .bu_target_i(bu_target_i), .bu_taken_i(bu_taken_i),
        .pc_o(pc_w), .pred_taken_o(pred_taken_w),
        .pred_target_o(pred_target_w), .pending_o(pending_w)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic push(input string n, input logic [31:0] pc,
                        input logic pend, input logic pt,
                        input logic [31:0] ptgt);
        exp_t e;
        e.name = n; e.pc = pc; e.pend = pend; e.pt = pt; e.ptgt = ptgt;
        sb.push_back(e);
    endtask

    // Advance one active edge, then pop and compare one scoreboard entry.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_empty: observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            chk({e.name, ".pc"},   pc_o,                 e.pc);
            chk({e.name, ".pend"}, {31'd0, pending_o},    {31'd0, e.pend});
            chk({e.name, ".pt"},   {31'd0, pred_taken_o}, {31'd0, e.pt});
            chk({e.name, ".ptgt"}, pred_target_o,        e.ptgt);
        end
    endtask

    task automatic rd(input logic [1:0] v, input logic [31:0] t0,
                      input logic [31:0] t1);
        rd_valid_i  = v;
        rd_target_i = {t1, t0};
    endtask

    task automatic bu(input logic v, input logic [31:0] p,
                      input logic [31:0] t, input logic tk);
        bu_valid_i = v; bu_pc_i = p; bu_target_i = t; bu_taken_i = tk;
    endtask

    initial begin
        rst = 1'b0;
        stall_i = 1'b0;
        rd(2'b00, 0, 0);
        bu(1'b0, 0, 0, 1'b0);

        push("rst_a", 32'h0, 0, 0, 0); tick();
        push("rst_b", 32'h0, 0, 0, 0); tick();
        chk("wrap_reset", pc_w, 32'hFFFF_FFFC);

        rst = 1'b1;
        push("seq4", 32'h4, 0, 0, 0); tick();
        chk("wrap_next", pc_w, 32'h0);
        push("seq8", 32'h8, 0, 0, 0); tick();
        push("seq12", 32'hC, 0, 0, 0); tick();
        push("seq16", 32'h10, 0, 0, 0); tick();

        rd(2'b11, 32'h200, 32'h300);
        push("both_rd", 32'h200, 0, 0, 0); tick();
        rd(2'b10, 0, 32'h20);
        push("ch1_rd", 32'h20, 0, 0, 0); tick();

        stall_i = 1'b1; rd(2'b10, 0, 32'h80);
        push("stall_rd1", 32'h20, 1, 0, 0); tick();
        rd(2'b01, 32'h90, 0);
        push("stall_rd0", 32'h20, 1, 0, 0); tick();
        stall_i = 1'b0; rd(2'b00, 0, 0);
        push("pend_drain", 32'h90, 0, 0, 0); tick();

        stall_i = 1'b1; rd(2'b10, 0, 32'hA0);
        push("stall_again", 32'h90, 1, 0, 0); tick();
        stall_i = 1'b0; rd(2'b10, 0, 32'hB0);
        push("live_wins", 32'hB0, 0, 0, 0); tick();
        rd(2'b00, 0, 0);
        push("after_live", 32'hB4, 0, 0, 0); tick();

        stall_i = 1'b1; bu(1'b1, 32'h40, 32'h100, 1'b1);
        push("train_stall", 32'hB4, 0, 0, 0); tick();
        stall_i = 1'b0; bu(1'b0, 0, 0, 1'b0); rd(2'b01, 32'h40, 0);
        push("hit40", 32'h40, 0, 1, 32'h100); tick();
        rd(2'b00, 0, 0);
        push("pred_follow", 32'h100, 0, 0, 0); tick();
        rd(2'b01, 32'h60, 0);
        push("alias60", 32'h60, 0, 0, 0); tick();
        rd(2'b00, 0, 0);
        push("alias_seq", 32'h64, 0, 0, 0); tick();
        rd(2'b01, 32'h40, 0); bu(1'b1, 32'h60, 32'h0, 1'b0);
        push("nt_nomatch", 32'h40, 0, 1, 32'h100); tick();
        rd(2'b00, 0, 0); bu(1'b0, 0, 0, 1'b0);
        push("pred_again", 32'h100, 0, 0, 0); tick();
        rd(2'b01, 32'h40, 0); bu(1'b1, 32'h40, 32'h0, 1'b0);
        push("nt_clear", 32'h40, 0, 0, 0); tick();
        rd(2'b00, 0, 0); bu(1'b0, 0, 0, 1'b0);
        push("seq_44", 32'h44, 0, 0, 0); tick();

        bu(1'b1, 32'h44, 32'h300, 1'b1);
        push("old_lookup", 32'h48, 0, 0, 0); tick();
        bu(1'b0, 0, 0, 1'b0); rd(2'b01, 32'h44, 0);
        push("hit44", 32'h44, 0, 1, 32'h300); tick();
        rd(2'b00, 0, 0);
        push("pred300", 32'h300, 0, 0, 0); tick();

        stall_i = 1'b1; rd(2'b01, 32'h500, 0);
        push("pend_set", 32'h300, 1, 0, 0); tick();
        rst = 1'b0; rd(2'b01, 32'h600, 0); bu(1'b1, 32'h0, 32'h700, 1'b1);
        push("mid_rst", 32'h0, 0, 0, 0); tick();
        rst = 1'b1; stall_i = 1'b0; rd(2'b00, 0, 0); bu(1'b0, 0, 0, 1'b0);
        push("post_rst", 32'h4, 0, 0, 0); tick();
        rd(2'b01, 32'h44, 0);
        push("miss44", 32'h44, 0, 0, 0); tick();
        rd(2'b00, 0, 0);
        push("miss_seq", 32'h48, 0, 0, 0); tick();

        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL sb_left: observed=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
